// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART buffer blocks.
package uart_pkg;

    localparam int UART_TXBUF_DEPTH = 16;

    // Drain controller states: IDLE waits for a byte and a free transmitter,
    // SEND holds the current byte until the transmitter reports completion.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } txbuf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and sticky overflow flag.
// Read data is the head entry, visible combinationally; rd_en retires it.
// The reader must only assert rd_en while the FIFO is not empty.
// Full/empty are decoded from the count, so pointers simply wrap.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic             push;
    logic             drop;

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push    = wr_en && (!full || rd_en);
    assign drop    = wr_en && full && !rd_en;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rp];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag (a drop wins over a clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (rd_en) begin
                rp <= rp + 1'b1;
            end
            case ({push, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Byte buffer in front of uart_tx: the bus side pushes freely, the drain FSM
// hands one byte at a time to the transmitter.
// Handshake with uart_tx: tx_start is a single-cycle request issued only when
// tx_busy is low; tx_data is held from tx_start until the tx_end pulse that
// closes that byte, and tx_end seen while IDLE is ignored.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXBUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [7:0]     wr_data,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count,
    output logic           ovf,
    input  logic           ovf_clr,
    output logic           done_irq,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic           tx_busy,
    input  logic           tx_end,
    output logic           fsm_state
);

    txbuf_state_e state;
    txbuf_state_e state_nxt;
    logic         pop;
    logic [7:0]   head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    assign fsm_state = (state == SEND);

    // Next state and pop decision; uses the registered empty flag, so a byte
    // pushed into an empty buffer is only popped on the following cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the registered transmitter-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            done_irq <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_start <= pop;
            if (pop) begin
                tx_data <= head;
            end
            done_irq <= (state == SEND) && tx_end && empty;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: a simple transmitter model with a short bit time,
// a queue-based reference of the buffer, and directed plus random stimulus.
module tb_uart_tx_buf;

    localparam int DEPTH    = 16;
    localparam int PTR_W    = 4;
    localparam int BIT_CLKS = 2;
    localparam int FRAME    = BIT_CLKS * 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_en = 1'b0;
    logic [7:0]     wr_data = 8'h00;
    logic           ovf_clr = 1'b0;
    logic           tx_busy = 1'b0;
    logic           tx_end = 1'b0;
    logic           full;
    logic           empty;
    logic [PTR_W:0] count;
    logic           ovf;
    logic           done_irq;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           fsm_state;

    // reference model state
    logic [7:0] exp_q[$];
    bit         in_send = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_data = 8'h00;

    // transmitter model state
    bit         stall = 0;
    bit         stray_end = 0;
    bit         u_busy = 0;
    bit         u_end = 0;
    int         u_cnt = 0;
    logic [7:0] u_byte = 8'h00;
    logic [7:0] rx_byte = 8'h00;

    int n_tests = 0;
    int n_fail = 0;
    int n_start_obs = 0;
    int n_done_obs = 0;

    always #5 clk = ~clk;

    uart_tx_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .done_irq  (done_irq),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_end    (tx_end),
        .fsm_state (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample inputs at the edge, update the reference, check all
    // outputs on the falling edge, then advance the transmitter model.
    task automatic step();
        logic       s_wr, s_clr, s_busy, s_end, s_rst;
        logic [7:0] s_data;
        int         pre_size;
        bit         pre_send, e_pop, e_done, drop;
        int         bit_idx;
        tx_busy = u_busy || stall;
        tx_end  = u_end || stray_end;
        @(posedge clk);
        s_wr = wr_en; s_data = wr_data; s_clr = ovf_clr;
        s_busy = tx_busy; s_end = tx_end; s_rst = rst;
        pre_size = exp_q.size();
        pre_send = in_send;
        @(negedge clk);
        e_pop = 0;
        e_done = 0;
        if (!s_rst) begin
            exp_q.delete();
            in_send  = 0;
            exp_ovf  = 1'b0;
            exp_data = 8'h00;
        end else begin
            e_pop  = !pre_send && pre_size > 0 && !s_busy;
            e_done = pre_send && s_end && pre_size == 0;
            drop   = s_wr && pre_size == DEPTH && !e_pop;
            if (e_pop) begin
                exp_data = exp_q.pop_front();
                in_send  = 1;
            end else if (pre_send && s_end) begin
                in_send = 0;
            end
            if (s_wr && !drop) exp_q.push_back(s_data);
            if (drop) exp_ovf = 1'b1;
            else if (s_clr) exp_ovf = 1'b0;
        end
        check("tx_start", tx_start, e_pop);
        check("tx_data", tx_data, exp_data);
        check("count", count, exp_q.size());
        check("full", full, exp_q.size() == DEPTH);
        check("empty", empty, exp_q.size() == 0);
        check("ovf", ovf, exp_ovf);
        check("done_irq", done_irq, e_done);
        check("state", fsm_state, in_send);
        if (tx_start === 1'b1) n_start_obs++;
        if (done_irq === 1'b1) n_done_obs++;
        // transmitter model: start, 8 data bits LSB first, stop
        if (!s_rst) begin
            u_busy = 0; u_end = 0; u_cnt = 0;
        end else begin
            u_end = 0;
            if (u_busy) begin
                bit_idx = u_cnt / BIT_CLKS;
                if (u_cnt % BIT_CLKS == BIT_CLKS / 2 && bit_idx >= 1 && bit_idx <= 8)
                    rx_byte = {u_byte[bit_idx-1], rx_byte[7:1]};
                u_cnt++;
                if (u_cnt == FRAME) begin
                    u_busy = 0;
                    u_end  = 1;
                end
            end else if (tx_start === 1'b1) begin
                u_busy = 1;
                u_cnt  = 0;
                u_byte = tx_data;
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && !(exp_q.size() == 0 && !in_send && !u_busy); i++) step();
        check("drain_timeout", (exp_q.size() != 0 || in_send), 0);
        repeat (2) step();
    endtask

    initial begin
        int s0, d0, i;
        // reset
        repeat (3) step();
        rst = 1'b1;
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_ovf", ovf, 0);
        step();

        // single byte
        s0 = n_start_obs; d0 = n_done_obs;
        push(8'hA5);
        drain();
        check("t2_starts", n_start_obs - s0, 1);
        check("t2_line", rx_byte, 8'hA5);
        check("t2_done", n_done_obs - d0, 1);
        check("t2_count", count, 0);

        // burst of 16
        s0 = n_start_obs;
        for (int b = 1; b <= 16; b++) push(8'(b));
        drain();
        check("t3_starts", n_start_obs - s0, 16);

        // overflow with drain stalled
        stall = 1;
        step();
        for (int b = 0; b < 17; b++) push(8'(8'h40 + b));
        check("t4_count", count, 16);
        check("t4_ovf", ovf, 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("t4_ovf_clr", ovf, 0);
        ovf_clr = 1'b1; push(8'h77); ovf_clr = 1'b0;
        check("t4_ovf_set_wins", ovf, 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

        // full with simultaneous push and pop
        stall = 0;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        check("t5_count", count, 16);
        check("t5_ovf", ovf, 0);
        check("t5_start", tx_start, 1);
        drain();

        // tx_end while idle
        stray_end = 1; step(); stray_end = 0;
        step();
        check("stray_state", fsm_state, 0);

        // reset during the third bit of the first of four bytes
        for (int b = 0; b < 4; b++) push(8'(8'hC0 + b));
        for (i = 0; i < 200 && !(u_busy && u_cnt / BIT_CLKS == 3); i++) step();
        check("t6_reach", (u_busy && u_cnt / BIT_CLKS == 3), 1);
        rst = 1'b0;
        #1;
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_tx_data", tx_data, 8'h00);
        check("t6_state", fsm_state, 0);
        step(); step();
        rst = 1'b1;
        s0 = n_start_obs;
        repeat (50) step();
        check("t6_no_start", n_start_obs - s0, 0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom_range(0, 255));
            ovf_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) stall = !stall;
            step();
        end
        wr_en = 1'b0; ovf_clr = 1'b0; stall = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
